// File: rtl/spu_voicekeyscheduler.sv
// SPU voice key scheduler: 24-voice x 32-slot timebase, pending KON/KOFF masks,
// per-voice key event application and ADSR sample strobe generation.
module spu_voicekeyscheduler #(
  parameter int unsigned VOICES      = 24,
  parameter int unsigned SLOTS       = 32,
  parameter int unsigned APPLY_SLOT  = 0,
  parameter int unsigned SAMPLE_SLOT = 2
) (
  input  logic              i_clk,
  input  logic              n_rst,
  input  logic              i_SPUEnable,
  input  logic              i_konWrite,
  input  logic              i_koffWrite,
  input  logic              i_writeUpper,
  input  logic [15:0]       i_writeData,
  input  logic              i_clearKON,
  output logic [4:0]        o_voiceIndex,
  output logic [4:0]        o_voiceSlot,
  output logic              o_validSampleStage2,
  output logic              o_applyKON,
  output logic              o_applyKOFF,
  output logic [VOICES-1:0] o_konActive,
  output logic [VOICES-1:0] o_pendingKON,
  output logic [VOICES-1:0] o_pendingKOFF
);

  localparam int unsigned IW         = 5;
  localparam int unsigned UPPER_BASE = 16;

  logic [IW-1:0]     voice_n;
  logic [IW-1:0]     slot_n;
  logic [VOICES-1:0] cur_bit;
  logic [VOICES-1:0] wr_mask;
  logic [VOICES-1:0] pend_kon_n;
  logic [VOICES-1:0] pend_koff_n;
  logic [VOICES-1:0] ka_n;
  logic              apply_kon_n;
  logic              apply_koff_n;
  logic              strobe_n;
  logic              fired_q;
  logic              fired_n;

  // Next-state: timebase advance, pending mask update, key event decision.
  // A voice's pending bit is retired at the end of its pulse cycle, so a write
  // landing in that cycle re-arms it for the next sample period.
  always_comb begin
    voice_n      = '0;
    slot_n       = '0;
    pend_kon_n   = '0;
    pend_koff_n  = '0;
    apply_kon_n  = 1'b0;
    apply_koff_n = 1'b0;
    strobe_n     = 1'b0;
    fired_n      = 1'b0;
    cur_bit      = VOICES'(1) << o_voiceIndex;
    wr_mask      = i_writeUpper ? (VOICES'(i_writeData[7:0]) << UPPER_BASE)
                                : VOICES'(i_writeData);
    ka_n         = (o_konActive & ~(((o_applyKOFF || i_clearKON)) ? cur_bit : '0))
                 | (o_applyKON ? cur_bit : '0);

    if (i_SPUEnable) begin
      fired_n = fired_q;
      if (32'(o_voiceSlot) == SLOTS - 1) begin
        slot_n  = '0;
        voice_n = (32'(o_voiceIndex) == VOICES - 1) ? '0 : o_voiceIndex + IW'(1);
      end else begin
        slot_n  = o_voiceSlot + IW'(1);
        voice_n = o_voiceIndex;
      end

      pend_kon_n  = (o_pendingKON  & ~(o_applyKON  ? cur_bit : '0))
                  | (i_konWrite  ? wr_mask : '0);
      pend_koff_n = (o_pendingKOFF & ~(o_applyKOFF ? cur_bit : '0))
                  | (i_koffWrite ? wr_mask : '0);

      // KON takes priority; a coexisting KOFF waits for the next sample period.
      if (32'(slot_n) == APPLY_SLOT) begin
        apply_kon_n  = pend_kon_n[voice_n];
        apply_koff_n = !pend_kon_n[voice_n] && pend_koff_n[voice_n];
        fired_n      = apply_kon_n || apply_koff_n;
      end

      strobe_n = (32'(slot_n) == SAMPLE_SLOT) && !fired_n;
    end
  end

  always_ff @(posedge i_clk or negedge n_rst) begin
    if (!n_rst) begin
      o_voiceIndex        <= '0;
      o_voiceSlot         <= '0;
      o_validSampleStage2 <= 1'b0;
      o_applyKON          <= 1'b0;
      o_applyKOFF         <= 1'b0;
      o_konActive         <= '0;
      o_pendingKON        <= '0;
      o_pendingKOFF       <= '0;
      fired_q             <= 1'b0;
    end else begin
      o_voiceIndex        <= voice_n;
      o_voiceSlot         <= slot_n;
      o_validSampleStage2 <= strobe_n;
      o_applyKON          <= apply_kon_n;
      o_applyKOFF         <= apply_koff_n;
      o_konActive         <= ka_n;
      o_pendingKON        <= pend_kon_n;
      o_pendingKOFF       <= pend_koff_n;
      fired_q             <= fired_n;
    end
  end

endmodule
